// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronise and debounce two raw coin lines, queue
// accepted coins, and issue them one per cycle as the vending machine's 2-bit code.

module coin_acceptor_deb #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic coin_ev
);
  localparam int CW = 8;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Any cycle of agreement restarts the persistence count.
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign coin_ev = stable_q & ~prev_q;
endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          hold,
  output logic [1:0]                    in_code,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0] raw_vec;
  logic [1:0] ev;

  assign raw_vec = {coin10_raw, coin5_raw};

  // Channel 0 is the 5-unit sensor, channel 1 the 10-unit sensor.
  for (genvar ch = 0; ch < 2; ch++) begin : g_deb
    coin_acceptor_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw     (raw_vec[ch]),
      .coin_ev (ev[ch])
    );
  end

  logic [FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
  logic [AW-1:0]              wr_q, wr_d;
  logic [AW-1:0]              rd_q, rd_d;
  logic [CW-1:0]              count_q, count_d;
  logic [1:0]                 in_code_q, in_code_d;
  logic                       reject_q, reject_d;

  logic       pop, push, one_ev, both_ev;
  logic [1:0] push_code;

  always_comb begin
    pop       = !hold && (count_q != '0);
    one_ev    = ev[0] ^ ev[1];
    both_ev   = ev[0] & ev[1];
    // A pop in the same cycle frees the slot a push into a full queue needs.
    push      = one_ev && ((count_q != DEPTH_C) || pop);
    push_code = ev[1] ? 2'b10 : 2'b01;

    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;

    if (push) begin
      mem_d[wr_q] = push_code;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    in_code_d = pop ? mem_q[rd_q] : 2'b00;
    reject_d  = both_ev | (one_ev & ~push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      in_code_q <= 2'b00;
      reject_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      in_code_q <= in_code_d;
      reject_q  <= reject_d;
    end
  end

  assign in_code    = in_code_q;
  assign reject     = reject_q;
  assign fifo_count = count_q;
  assign full       = (count_q == DEPTH_C);
endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised bench for coin_acceptor: a window-based reference model predicts
// every issued code and reject pulse; a negedge monitor pops and compares them.

module tb_coin_acceptor;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, c5, c10, hold;
  logic [1:0] in_code;
  logic       reject;
  logic [2:0] fifo_count;
  logic       full;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (c5),
    .coin10_raw (c10),
    .hold       (hold),
    .in_code    (in_code),
    .reject     (reject),
    .fifo_count (fifo_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t eq[$];
  int   rq[$];
  int   fq[$];

  // Reference model state: sensor samples, last D synchronised samples, accepted level.
  logic [1:0]   m_s1, m_s2, m_stab, m_ev, raw_now;
  logic [D-1:0] win [2];
  bit           m_pop, m_room;
  exp_t         m_e, mon_e;
  int           mon_r;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      fq.delete(); eq.delete(); rq.delete();
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_ev = '0;
      win[0] = '0; win[1] = '0;
    end else begin
      cyc++;
      raw_now = {c10, c5};
      m_pop  = !hold && fq.size() > 0;
      m_room = fq.size() < DEPTH || m_pop;
      if (m_pop) begin
        m_e.code = 2'(fq.pop_front());
        m_e.cyc  = cyc;
        eq.push_back(m_e);
      end
      if (m_ev == 2'b11) rq.push_back(cyc);
      else if (m_ev != 2'b00) begin
        if (m_room) fq.push_back(m_ev[1] ? 2 : 1);
        else        rq.push_back(cyc);
      end
      // A level is accepted once the synchronised line has shown it for D straight cycles.
      for (int ch = 0; ch < 2; ch++) begin
        win[ch] = {win[ch][D-2:0], m_s2[ch]};
        if (win[ch] == {D{~m_stab[ch]}}) begin
          m_stab[ch] = ~m_stab[ch];
          m_ev[ch]   = m_stab[ch];
        end else begin
          m_ev[ch] = 1'b0;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw_now[ch];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (in_code !== 2'b00) begin
        checks++;
        if (eq.size() == 0) begin
          failures++;
          $display("FAIL in_code: got %b at cycle %0d, expected 00", in_code, cyc);
        end else begin
          mon_e = eq.pop_front();
          if (mon_e.code !== in_code || mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL in_code: got %b at cycle %0d, expected %b at cycle %0d",
                     in_code, cyc, mon_e.code, mon_e.cyc);
          end
        end
      end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
        checks++; failures++;
        mon_e = eq.pop_front();
        $display("FAIL in_code missing: got 00 at cycle %0d, expected %b", cyc, mon_e.code);
      end
      if (reject !== 1'b0) begin
        checks++;
        if (rq.size() == 0 || rq[0] != cyc) begin
          failures++;
          $display("FAIL reject: got 1 at cycle %0d, expected 0", cyc);
        end
        if (rq.size() > 0 && rq[0] <= cyc) mon_r = rq.pop_front();
      end else if (rq.size() > 0 && rq[0] <= cyc) begin
        checks++; failures++;
        mon_r = rq.pop_front();
        $display("FAIL reject missing: got 0 at cycle %0d, expected 1 at cycle %0d", cyc, mon_r);
      end
      checks++;
      if (fifo_count !== 3'(fq.size()) || full !== (fq.size() == DEPTH)) begin
        failures++;
        $display("FAIL occupancy: got count=%0d full=%b, expected count=%0d full=%b at cycle %0d",
                 fifo_count, full, fq.size(), fq.size() == DEPTH, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic coin(input int ch, input int hi, input int lo);
    if (ch == 0) c5 = 1'b1; else c10 = 1'b1;
    step(hi);
    c5 = 1'b0; c10 = 1'b0;
    step(lo);
  endtask

  // Line must already be high; the next edge is the first sample (edge 0).
  task automatic measure(input logic [1:0] code, output int lat);
    lat = -1;
    @(posedge clk);
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (in_code == code) lat = k;
      else @(posedge clk);
    end
  endtask

  int lat;
  int r;

  initial begin
    rst = 1'b1; c5 = 1'b0; c10 = 1'b0; hold = 1'b0;
    step(2);
    #1;
    chk("reset in_code", int'(in_code), 0);
    chk("reset reject", int'(reject), 0);
    chk("reset fifo_count", int'(fifo_count), 0);
    chk("reset full", int'(full), 0);
    rst = 1'b0;
    step(1);

    c5 = 1'b1;
    measure(2'b01, lat);
    chk("coin5 latency", lat, D + 3);
    step(2); c5 = 1'b0; step(8);

    c10 = 1'b1; step(2); c10 = 1'b0; step(2);
    for (int k = 0; k < 8; k++) begin c10 = ~c10; step(1); end
    c10 = 1'b0; step(8);
    coin(1, 6, 8);

    hold = 1'b1;
    coin(0, 6, 6); coin(1, 6, 6); coin(0, 6, 6); coin(1, 6, 6);
    chk("held count", int'(fifo_count), 4);
    chk("held full", int'(full), 1);
    coin(0, 6, 6);
    hold = 1'b0; step(8);

    c5 = 1'b1; c10 = 1'b1; step(8);
    c5 = 1'b0; c10 = 1'b0; step(8);

    hold = 1'b1;
    coin(0, 6, 6); coin(1, 6, 6); coin(0, 6, 6); coin(1, 6, 6);
    c5 = 1'b1;
    step(6);
    hold = 1'b0;
    @(negedge clk);
    chk("push+pop count", int'(fifo_count), 4);
    chk("push+pop reject", int'(reject), 0);
    step(2); c5 = 1'b0; step(12);

    hold = 1'b1;
    coin(1, 6, 6); coin(0, 6, 6); coin(1, 6, 6); coin(0, 6, 6);
    hold = 1'b0;
    step(1);
    chk("pre-reset in_code", int'(in_code), 2);
    chk("pre-reset count", int'(fifo_count), 3);
    c5 = 1'b1;
    rst = 1'b1;
    #1;
    chk("async rst in_code", int'(in_code), 0);
    chk("async rst reject", int'(reject), 0);
    chk("async rst count", int'(fifo_count), 0);
    chk("async rst full", int'(full), 0);
    step(2);
    rst = 1'b0;
    measure(2'b01, lat);
    chk("post-reset latency", lat, D + 3);
    step(2); c5 = 1'b0; step(10);

    repeat (60) begin
      r = $urandom_range(0, 9);
      hold = ($urandom_range(0, 3) == 0);
      if (r <= 5) coin(int'($urandom_range(0, 1)), int'($urandom_range(1, 8)), int'($urandom_range(0, 8)));
      else if (r == 6) begin
        c5 = 1'b1; c10 = 1'b1; step($urandom_range(2, 7));
        c5 = 1'b0; c10 = 1'b0; step($urandom_range(0, 6));
      end else if (r <= 8) begin
        for (int k = 0; k < 6; k++) begin c5 = 1'($urandom); c10 = 1'($urandom); step(1); end
        c5 = 1'b0; c10 = 1'b0;
      end else step($urandom_range(1, 10));
    end

    c5 = 1'b0; c10 = 1'b0; hold = 1'b0;
    step(40);
    checks++;
    if (eq.size() != 0 || rq.size() != 0 || fq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d codes %0d rejects %0d queued pending, expected 0",
               eq.size(), rq.size(), fq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that sits directly upstream of `vending_machine`. It conditions two raw mechanical coin-sensor lines (5-unit and 10-unit), synchronises and debounces them, and queues accepted coins in a small FIFO. It then issues them one per cycle as the 2-bit `in` code the vending machine consumes: 00 = none, 01 = 5, 10 = 10. Coins that cannot be accepted are rejected with a pulse that drives the return-chute actuator.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised level must persist before it is accepted; legal range 2–255.
- `FIFO_DEPTH`, 4: coin queue depth; power of two, 2–16.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `coin5_raw`  in  1  raw 5-unit sensor; asynchronous, may bounce.
- `coin10_raw`  in  1  raw 10-unit sensor; asynchronous, may bounce.
- `hold`  in  1  downstream stall; while 1, no coin is issued.
- `in_code`  out  2  coin code to `vending_machine.in`; registered.
- `reject`  out  1  one-cycle pulse per dropped coin; registered.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  coins currently queued.
- `full`  out  1  `fifo_count == FIFO_DEPTH`.

## Operation
- One clock domain; asynchronous active-high reset on every flop.
- Reset values: `in_code`=00, `reject`=0, `fifo_count`=0, `full`=0. Synchronisers, stable levels, debounce counters and FIFO pointers all reset to 0.
- Synchroniser: each raw line passes through 2 flops (`s1`, `s2`).
- Debounce runs per channel, with a counter and a stable level.
  - `s2 == stable`: counter clears to 0.
  - `s2 != stable` and counter == DEBOUNCE_CYCLES-1: `stable <= s2`, counter clears.
  - Otherwise the counter increments.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Coin event: rising edge of `stable` (a one-cycle pulse, compared against the registered previous `stable`). Falling edges are ignored.
- Push rules, evaluated in the event cycle:
  - Exactly one channel has an event and (FIFO not full, or a pop occurs in the same cycle): push its code (01 or 10).
  - Both channels have events in the same cycle: neither is pushed; `reject` pulses once.
  - One event, FIFO full, no pop in that cycle: the coin is dropped; `reject` pulses.
- Pop rule: if `hold`=0 and the FIFO is non-empty, pop the head and register it into `in_code`. Otherwise register 00.
- Simultaneous push and pop keeps `fifo_count` unchanged.
- Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- Code 11 is never produced.
- Reset mid-operation: queued and in-flight coins are lost. If a raw line is still high when reset releases, it is debounced afresh and counted as a new coin (stable resets to 0).

## Timing
- Edge 0 is the first edge at which `s1` samples a raw line high (line held high).
  - `s2` is high after edge 1.
  - Mismatch is counted at edges 2 through D+1 (D = DEBOUNCE_CYCLES); `stable` rises at edge D+1.
  - The event cycle follows edge D+1; push occurs at edge D+2.
  - Pop and `in_code` register at edge D+3.
- Latency from edge 0 to `in_code` valid: D+3 edges, with an empty FIFO and `hold`=0. For D=4, `in_code` is valid in the cycle after edge 7.
- `in_code` is non-zero for exactly one cycle per coin. Back-to-back queued coins issue on consecutive cycles.
- `reject` is asserted in the cycle after the push edge (registered, 1 cycle).
- `hold` is sampled at the pop edge. Raising `hold` suppresses the next issue; the head is preserved.
- Minimum spacing between coins on the same channel: the line must be low for ≥D cycles between coins, otherwise the events merge into one.

## Test plan
- Reset, then a clean 10-cycle high on `coin5_raw` (D=4) -> `in_code`=01 for exactly 1 cycle, 7 edges after the first sample. `fifo_count` goes 0→1→0. `reject` stays 0.
- 2-cycle glitch on `coin10_raw`, then 8 bouncy cycles alternating every cycle -> no `in_code` activity and no `reject`. A subsequent clean 6-cycle pulse -> one `in_code`=10.
- `hold`=1, then insert 5-, 10-, 5- and 10-unit coins, then one more 5-unit coin -> `fifo_count` reaches 4 and `full`=1; the fifth coin gives `reject`=1 for 1 cycle. Release `hold` -> `in_code` shows 01, 10, 01, 10 on 4 consecutive cycles.
- Both raw lines rise in the same cycle -> `reject` pulses once, `fifo_count` stays 0, `in_code` stays 00.
- FIFO full with `hold`=0 going low in the same cycle a new coin's push lands -> coin accepted, no `reject`, `fifo_count` stays 4 that cycle.
- Assert `rst` asynchronously mid-queue (`fifo_count`=3, `in_code`=10) -> all outputs 0 immediately, before the next edge. With `coin5_raw` held high across reset, exactly one 01 appears D+3 edges after reset release.
